// File: rtl/fir_axis_pkg.sv
// Shared definitions for the FIR output-side AXI-Stream buffer:
// default sample width, FIFO entry layout and the occupancy-width helper.
package fir_axis_pkg;

  localparam int P_DATA_WIDTH = 32;

  typedef struct packed {
    logic                    last;
    logic [P_DATA_WIDTH-1:0] data;
  } fir_entry_t;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fir_outbuf_mem.sv
// Register-array FIFO store: one synchronous write port and one
// combinational read port, addressed by the top's pointers.
module fir_outbuf_mem #(
  parameter int pWIDTH = 33,
  parameter int pDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [$clog2(pDEPTH)-1:0] i_waddr,
  input  logic [pWIDTH-1:0]         i_wdata,
  input  logic [$clog2(pDEPTH)-1:0] i_raddr,
  output logic [pWIDTH-1:0]         o_rdata
);

  logic [pWIDTH-1:0] r_mem [pDEPTH];

  // Contents need no reset: the top never presents an unwritten entry.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fir_axis_outbuf.sv
// Output buffer behind the FIR: FIFO that absorbs consumer back-pressure,
// registered first-word-fall-through head, and per-frame length checking.
module fir_axis_outbuf
  import fir_axis_pkg::*;
#(
  parameter int pDATA_WIDTH = P_DATA_WIDTH,
  parameter int pDEPTH      = 8,
  parameter int pCNT_WIDTH  = 16
) (
  input  logic                      axis_clk,
  input  logic                      axis_rst_n,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [pDATA_WIDTH-1:0]    s_tdata,
  input  logic                      s_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [pDATA_WIDTH-1:0]    m_tdata,
  output logic                      m_tlast,
  input  logic [pCNT_WIDTH-1:0]     cfg_len,
  output logic [$clog2(pDEPTH):0]   level,
  output logic                      frame_done,
  output logic                      len_err,
  input  logic                      clr_err
);

  localparam int AW = $clog2(pDEPTH);
  localparam int LW = level_width(pDEPTH);
  localparam int EW = pDATA_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(pDEPTH);

  // Handshakes: a beat transfers on a rising edge where valid && ready;
  // valid never waits on ready, and m_* hold steady while stalled.
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_s_tready;
  logic [pDATA_WIDTH-1:0] r_m_data;
  logic                  r_m_last;
  logic                  r_frame_done;
  logic [pCNT_WIDTH-1:0] r_beat_cnt;
  logic                  r_len_err;

  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [AW-1:0]         w_rd_ptr_nxt;
  logic [LW-1:0]         w_level_nxt;
  logic [EW-1:0]         w_wr_entry;
  logic [EW-1:0]         w_rd_entry;
  logic [EW-1:0]         w_head_nxt;
  logic [pCNT_WIDTH:0]   w_n;
  logic [pCNT_WIDTH:0]   w_cfg_ext;
  logic                  w_len_bad;
  logic                  w_set_err;

  assign w_wr_en    = s_tvalid && r_s_tready;
  assign w_rd_en    = m_tvalid && m_tready;
  assign w_wr_entry = {s_tlast, s_tdata};
  assign w_rd_ptr_nxt = w_rd_en ? r_rd_ptr + AW'(1) : r_rd_ptr;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_en && !w_rd_en) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_wr_en && w_rd_en) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  fir_outbuf_mem #(
    .pWIDTH (EW),
    .pDEPTH (pDEPTH)
  ) u_mem (
    .clk     (axis_clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (w_rd_ptr_nxt),
    .o_rdata (w_rd_entry)
  );

  // The next head is the entry being written only when it lands exactly
  // at the next read slot (FIFO empty, or draining its last entry).
  assign w_head_nxt = (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) ? w_wr_entry : w_rd_entry;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_s_tready   <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_level      <= w_level_nxt;
      r_s_tready   <= (w_level_nxt < DEPTH_L);
      r_frame_done <= w_rd_en && r_m_last;
      if (w_level_nxt != '0) begin
        r_m_last <= w_head_nxt[EW-1];
        r_m_data <= w_head_nxt[pDATA_WIDTH-1:0];
      end
    end
  end

  // Frame checker: n is the 1-based index of the beat being accepted.
  assign w_n       = {1'b0, r_beat_cnt} + {{pCNT_WIDTH{1'b0}}, 1'b1};
  assign w_cfg_ext = {1'b0, cfg_len};
  assign w_len_bad = (cfg_len == '0) ||
                     (s_tlast ? (w_n != w_cfg_ext) : (w_n == w_cfg_ext));
  assign w_set_err = w_wr_en && w_len_bad;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_wr_en) begin
        if (s_tlast) begin
          r_beat_cnt <= '0;
        end else if (r_beat_cnt != {pCNT_WIDTH{1'b1}}) begin
          r_beat_cnt <= w_n[pCNT_WIDTH-1:0];
        end
      end
      if (w_set_err) begin
        r_len_err <= 1'b1;
      end else if (clr_err) begin
        r_len_err <= 1'b0;
      end
    end
  end

  assign s_tready   = r_s_tready;
  assign m_tvalid   = (r_level != '0);
  assign m_tdata    = r_m_data;
  assign m_tlast    = r_m_last;
  assign level      = r_level;
  assign frame_done = r_frame_done;
  assign len_err    = r_len_err;

endmodule

// File: tb/tb_fir_axis_outbuf.sv
// Directed bench for fir_axis_outbuf: scoreboard on the m side, per-cycle
// frame_done and stall-stability checks, plus directed frame-check cases.
module tb_fir_axis_outbuf;
  import fir_axis_pkg::*;

  localparam int W = $bits(fir_entry_t);

  logic        axis_clk;
  logic        axis_rst_n;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [15:0] cfg_len;
  logic [3:0]  level;
  logic        frame_done;
  logic        len_err;
  logic        clr_err;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  int fd_cnt   = 0;
  logic stress_done = 1'b0;

  logic [W-1:0] exp_q[$];
  logic         exp_fd = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W:0]   prev_m = '0;

  fir_axis_outbuf #(
    .pDATA_WIDTH (32),
    .pDEPTH      (8),
    .pCNT_WIDTH  (16)
  ) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .cfg_len    (cfg_len),
    .level      (level),
    .frame_done (frame_done),
    .len_err    (len_err),
    .clr_err    (clr_err)
  );

  // clock / reset
  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor / scoreboard: sampled on the falling edge, mid-cycle.
  always @(negedge axis_clk) begin
    if (!axis_rst_n) begin
      exp_q.delete();
      exp_fd     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_done", frame_done, exp_fd);
      if (frame_done) fd_cnt++;
      if (prev_stall) check("m_stable", {m_tvalid, m_tlast, m_tdata}, prev_m);
      if (s_tvalid && s_tready) begin
        exp_q.push_back({s_tlast, s_tdata});
        acc_cnt++;
      end
      if (m_tvalid && m_tready) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("sb_data", {m_tlast, m_tdata}, exp_q.pop_front());
      end
      exp_fd     = m_tvalid && m_tready && m_tlast;
      prev_stall = m_tvalid && !m_tready;
      prev_m     = {m_tvalid, m_tlast, m_tdata};
    end
  end

  // driver tasks: all input changes happen 1 ns after a rising edge
  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int t;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    t = 0;
    @(negedge axis_clk);
    while (!s_tready && t < 200) begin
      @(negedge axis_clk);
      t++;
    end
    step();
    s_tvalid = 1'b0;
    check("send_timeout", t < 200, 1);
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    @(negedge axis_clk);
    while (level != 0 && t < 300) begin
      @(negedge axis_clk);
      t++;
    end
    check("drain_timeout", t < 300, 1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  logic [31:0] pt_data [5];

  initial begin
    axis_rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    cfg_len  = 16'd5;
    clr_err  = 1'b0;
    pt_data[0] = 32'd10;
    pt_data[1] = -32'sd20;
    pt_data[2] = 32'd30;
    pt_data[3] = -32'sd40;
    pt_data[4] = 32'd50;

    // reset state
    repeat (2) @(negedge axis_clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_level", level, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_len_err", len_err, 0);
    step();
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    check("tready_before_edge", s_tready, 0);
    @(negedge axis_clk);
    check("tready_after_edge", s_tready, 1);

    // pass-through, first-beat latency
    step();
    send(pt_data[0], 1'b0);
    @(negedge axis_clk);
    check("lat_m_tvalid", m_tvalid, 1);
    check("lat_m_tdata", m_tdata, 32'd10);
    step();
    for (int i = 1; i < 5; i++) send(pt_data[i], i == 4);
    wait_empty();
    repeat (3) step();
    check("pt_frames", fd_cnt, 1);
    check("pt_len_err", len_err, 0);

    // back-pressure: 12 offered, 8 fit
    m_tready = 1'b0;
    cfg_len  = 16'd12;
    acc_cnt  = 0;
    for (int i = 0; i < 8; i++) send(32'h100 + i, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'h108;
    s_tlast  = 1'b0;
    repeat (3) begin
      @(negedge axis_clk);
      check("bp_level", level, 8);
      check("bp_s_tready", s_tready, 0);
    end
    step();
    check("bp_accepted", acc_cnt, 8);
    m_tready = 1'b1;
    for (int i = 8; i < 12; i++) send(32'h100 + i, i == 11);
    wait_empty();
    step();
    check("bp_total", acc_cnt, 12);
    check("bp_len_err", len_err, 0);

    // early tlast
    cfg_len = 16'd4;
    send(32'hA1, 1'b0);
    send(32'hA2, 1'b0);
    @(negedge axis_clk);
    check("early_no_err_yet", len_err, 0);
    step();
    send(32'hA3, 1'b1);
    @(negedge axis_clk);
    check("early_err", len_err, 1);
    step();
    pulse_clr();
    @(negedge axis_clk);
    check("early_clr", len_err, 0);

    // missing tlast
    step();
    cfg_len = 16'd3;
    send(32'hB1, 1'b0);
    send(32'hB2, 1'b0);
    @(negedge axis_clk);
    check("miss_no_err_yet", len_err, 0);
    step();
    send(32'hB3, 1'b0);
    @(negedge axis_clk);
    check("miss_err", len_err, 1);
    // clear coinciding with a new error keeps the flag set
    step();
    clr_err = 1'b1;
    send(32'hB4, 1'b1);
    clr_err = 1'b0;
    @(negedge axis_clk);
    check("set_beats_clr", len_err, 1);
    step();
    pulse_clr();
    @(negedge axis_clk);
    check("clr_alone", len_err, 0);

    // cfg_len = 0: any beat is an error
    step();
    cfg_len = 16'd0;
    send(32'hC1, 1'b0);
    @(negedge axis_clk);
    check("len0_err", len_err, 1);
    step();
    send(32'hC2, 1'b1);
    pulse_clr();
    wait_empty();

    // reset mid-frame
    step();
    m_tready = 1'b0;
    cfg_len  = 16'd8;
    for (int i = 0; i < 4; i++) send(32'hD0 + i, 1'b0);
    @(negedge axis_clk);
    check("mid_level", level, 4);
    step();
    axis_rst_n = 1'b0;
    @(negedge axis_clk);
    check("mid_rst_level", level, 0);
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_s_tready", s_tready, 0);
    step();
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    check("mid_rel_s_tready0", s_tready, 0);
    @(negedge axis_clk);
    check("mid_rel_s_tready1", s_tready, 1);
    check("mid_rel_m_tvalid", m_tvalid, 0);
    step();
    m_tready = 1'b1;
    cfg_len  = 16'd2;
    fd_cnt   = 0;
    send(32'hE1, 1'b0);
    send(32'hE2, 1'b1);
    wait_empty();
    repeat (2) step();
    check("mid_next_frame", fd_cnt, 1);
    check("mid_next_len_err", len_err, 0);

    // random stress: one 500-beat frame
    cfg_len = 16'd500;
    fd_cnt  = 0;
    fork
      begin
        for (int i = 0; i < 500; i++) begin
          repeat ($urandom_range(0, 2)) step();
          send($urandom(), i == 499);
        end
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          step();
          m_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_tready = 1'b1;
    wait_empty();
    repeat (2) step();
    check("stress_frames", fd_cnt, 1);
    check("stress_len_err", len_err, 0);
    check("stress_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // hard stop if a wait ever escapes its bound
  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fir_axis_outbuf.md
# fir_axis_outbuf

Output-side AXI-Stream buffer placed directly downstream of `fir`. It takes `fir`'s `sm_*` stream into a small FIFO and re-drives it to the consumer. This decouples the FIR MAC pipeline from consumer back-pressure. It also checks each frame: the beat count must match the programmed `data_length`, and `tlast` must land on the last beat.

## Interface
Parameters:
- `pDATA_WIDTH`, 32, sample width (matches `fir`).
- `pDEPTH`, 8, FIFO entries; must be a power of two and at least 2.
- `pCNT_WIDTH`, 16, width of the frame length and beat counter.

Ports:
- `axis_clk`  in  1  single clock; all logic is rising-edge.
- `axis_rst_n`  in  1  asynchronous, active-low reset.
- `s_tvalid`  in  1  upstream valid; connects to `fir.sm_tvalid`.
- `s_tready`  out  1  upstream ready; connects to `fir.sm_tready`.
- `s_tdata`  in  pDATA_WIDTH  upstream data, signed.
- `s_tlast`  in  1  upstream end of frame.
- `m_tvalid`  out  1  downstream valid.
- `m_tready`  in  1  downstream ready.
- `m_tdata`  out  pDATA_WIDTH  downstream data.
- `m_tlast`  out  1  downstream end of frame.
- `cfg_len`  in  pCNT_WIDTH  expected beats per frame; same value as `fir` register 0x10.
- `level`  out  $clog2(pDEPTH)+1  current FIFO occupancy.
- `frame_done`  out  1  one-cycle pulse when the `tlast` beat leaves on the m side.
- `len_err`  out  1  sticky frame-length error flag.
- `clr_err`  in  1  synchronous clear of `len_err`.

## Operation
FIFO:
- Storage is `pDEPTH` entries of {tlast, tdata}, with separate write and read pointers of width $clog2(pDEPTH). Both pointers wrap modulo `pDEPTH`.
- Write: on `s_tvalid && s_tready`.
- Read: on `m_tvalid && m_tready`.
- `m_tvalid = (level != 0)`. `m_tdata` and `m_tlast` show the head entry (first-word fall-through, driven from a register).
- `s_tready` is registered and equals 1 when the next-cycle `level` is below `pDEPTH`. Full means no write. A read in the same cycle as full does not allow a same-cycle write; the freed slot shows as `s_tready`=1 on the following cycle.
- A simultaneous write and read leaves `level` unchanged. A write to an empty FIFO is visible on `m_*` one cycle later.

Frame checker (input side):
- `beat_cnt` (pCNT_WIDTH) counts accepted s beats in the current frame.
- On each accepted beat, let n = `beat_cnt`+1.
  - If `s_tlast`=1: `len_err` is set when n != `cfg_len`. `beat_cnt` then returns to 0.
  - If `s_tlast`=0: `len_err` is set when n == `cfg_len`, which means `tlast` is missing. `beat_cnt` becomes n and saturates at its maximum value.
- `cfg_len`=0: any accepted beat sets `len_err`.
- `cfg_len` is sampled on each beat; software only changes it between frames.
- Data always passes through unchanged. An error never drops or alters beats.
- `clr_err` has priority over a same-cycle set only when no error occurs that cycle. A set and a clear in the same cycle leave `len_err`=1.

## Timing
- Reset values: `s_tready`=0, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `level`=0, `frame_done`=0, `len_err`=0. Pointers and `beat_cnt` reset to 0.
- `s_tready` rises on the first clock edge after `axis_rst_n` deasserts.
- Latency from s acceptance to `m_tvalid` is 1 cycle when the FIFO is empty.
- Throughput is 1 beat/cycle sustained when `m_tready`=1.
- `frame_done` is asserted in the cycle after the read handshake of an entry with `tlast`=1.
- Reset mid-frame empties the FIFO and discards buffered beats. `beat_cnt` and `len_err` are cleared.
- AXI-Stream rule: once `m_tvalid`=1, it and `m_tdata`/`m_tlast` stay stable until `m_tready`.

## Structure
- Package `fir_axis_pkg`: `pDATA_WIDTH` default, FIFO entry struct {last, data}, and a `clog2` helper constant for `level` width.
- One sub-module `fir_outbuf_mem`: a register-array dual-port store (one write port, one combinational read port), indexed by the pointers.
- Pointers, `level`, `s_tready`, the output register and the frame checker stay in the top module.

## Test plan
- Pass-through: `cfg_len`=5, samples 10,-20,30,-40,50 with `tlast` on the 5th, `m_tready`=1. Required: identical data in order, `m_tlast` on 50, one `frame_done` pulse, `len_err`=0.
- Back-pressure: `m_tready`=0, 12 beats offered with `pDEPTH`=8. Required: exactly 8 accepted, `level`=8, `s_tready`=0. Then `m_tready`=1: all 12 beats emerge in order and `level` returns to 0.
- Early `tlast`: `cfg_len`=4, `tlast` on beat 3. Required: `len_err`=1 the cycle after beat 3, data still forwarded. `clr_err` then gives `len_err`=0.
- Missing `tlast`: `cfg_len`=3, no `tlast` on beat 3. Required: `len_err`=1 after beat 3.
- Reset mid-frame: 4 beats buffered, then `axis_rst_n` pulsed low. Required: `level`=0, `m_tvalid`=0, `s_tready`=0 during reset and 1 one cycle after release. Next frame with `cfg_len`=2 passes clean.
- Random stress: random `s_tvalid`/`m_tready`, 500-beat frame, `cfg_len`=500. Required: scoreboard match, no `len_err`, and `m_*` stable while stalled.
